// File: rtl/sync_fifo_ram.sv
// Single-clock show-ahead FIFO on an inferred RAM with 2-cycle read latency.
// A 3-entry prefetch queue hides the RAM latency and sustains one word per cycle.
module sync_fifo_ram #(
    parameter int    DATA_WIDTH        = 8,
    parameter int    ADDR_WIDTH        = 4,
    parameter int    ALMOST_FULL_LEVEL = (1 << ADDR_WIDTH) - 2,
    parameter string RAM_TYPE          = "auto"
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  almost_full
);
    localparam int                DEPTH      = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C    = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_LEVEL_C = (ADDR_WIDTH + 1)'(ALMOST_FULL_LEVEL);
    localparam logic [ADDR_WIDTH:0] ONE_C      = (ADDR_WIDTH + 1)'(1);

    generate
        if (ADDR_WIDTH < 2 || ALMOST_FULL_LEVEL < 1 || ALMOST_FULL_LEVEL > DEPTH ||
            RAM_TYPE == "") begin : g_bad_params
            $error("sync_fifo_ram: invalid parameter set");
        end
    endgenerate

    (* ram_style = RAM_TYPE *)
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH:0]   ram_cnt;
    logic [ADDR_WIDTH:0]   ram_cnt_nxt;
    logic [ADDR_WIDTH:0]   count_nxt;
    logic                  rd_vld1;
    logic                  rd_vld2;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] q_data     [3];
    logic [DATA_WIDTH-1:0] q_data_nxt [3];
    logic [2:0]            q_vld;
    logic [2:0]            q_vld_nxt;
    logic                  q_placed;
    logic [2:0]            reserved;
    logic                  push;
    logic                  pop;
    logic                  issue;

    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_valid = q_vld[0];
    assign out_data  = q_data[0];

    // Queue slots already spoken for; a same-cycle pop frees one so streaming has no bubbles.
    assign reserved = 3'(q_vld[0]) + 3'(q_vld[1]) + 3'(q_vld[2]) +
                      3'(rd_vld1) + 3'(rd_vld2) - 3'(pop);
    assign issue    = (ram_cnt != '0) && (reserved < 3'd3);

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + ONE_C;
            2'b01:   count_nxt = count - ONE_C;
            default: count_nxt = count;
        endcase
        ram_cnt_nxt = ram_cnt + (push ? ONE_C : '0) - (issue ? ONE_C : '0);
    end

    always_comb begin
        q_data_nxt = q_data;
        q_vld_nxt  = q_vld;
        q_placed   = 1'b0;
        if (pop) begin
            for (int i = 0; i < 2; i++) begin
                q_data_nxt[i] = q_data[i+1];
                q_vld_nxt[i]  = q_vld[i+1];
            end
            q_vld_nxt[2] = 1'b0;
        end
        if (rd_vld2) begin
            for (int i = 0; i < 3; i++) begin
                if (!q_placed && !q_vld_nxt[i]) begin
                    q_data_nxt[i] = rd_data;
                    q_vld_nxt[i]  = 1'b1;
                    q_placed      = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            rd_addr     <= '0;
            ram_cnt     <= '0;
            count       <= '0;
            in_ready    <= 1'b1;
            almost_full <= 1'b0;
            rd_vld1     <= 1'b0;
            rd_vld2     <= 1'b0;
            q_vld       <= '0;
            q_data      <= '{default: '0};
        end else if (clear) begin
            // In-flight reads are dropped by clearing their valid bits.
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            rd_addr     <= '0;
            ram_cnt     <= '0;
            count       <= '0;
            in_ready    <= 1'b1;
            almost_full <= 1'b0;
            rd_vld1     <= 1'b0;
            rd_vld2     <= 1'b0;
            q_vld       <= '0;
            q_data      <= '{default: '0};
        end else begin
            wr_ptr      <= wr_ptr + ADDR_WIDTH'(push);
            rd_ptr      <= rd_ptr + ADDR_WIDTH'(issue);
            if (issue) rd_addr <= rd_ptr;
            ram_cnt     <= ram_cnt_nxt;
            count       <= count_nxt;
            in_ready    <= (count_nxt != DEPTH_C);
            almost_full <= (count_nxt >= AF_LEVEL_C);
            rd_vld1     <= issue;
            rd_vld2     <= rd_vld1;
            q_vld       <= q_vld_nxt;
            q_data      <= q_data_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (push && !clear) mem[wr_ptr] <= in_data;
        rd_data <= mem[rd_addr];
    end

endmodule
